piano_melody_sequencer: RTL and testbench

- Sequencer and controller for the 12-key piano octave tone block.
- Plays a stored melody of up to DEPTH steps, where each step is {key, octave, rest, duration}.
- Drives one-hot piano_keys, octave_num and play_en into the tone block.
- Independently steers the tone block's volume to a target level by issuing edge-detected vol_up/vol_down pulses, with volume_monitor as feedback.

---
 rtl/piano_seq_pkg.sv | 49 ++++
 rtl/piano_melody_sequencer_vol_tracker.sv | 51 +++++
 rtl/piano_melody_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_piano_melody_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_seq_pkg.sv
// Shared types and constants for the piano melody sequencer.
package piano_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        NOTE = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int unsigned NUM_KEYS = 12;
    localparam int unsigned ENTRY_W  = 16;

    // Melody entry layout: {key[3:0], octave[2:0], rest, duration[7:0]}
    localparam int unsigned KEY_MSB  = 15;
    localparam int unsigned KEY_LSB  = 12;
    localparam int unsigned OCT_MSB  = 11;
    localparam int unsigned OCT_LSB  = 9;
    localparam int unsigned REST_BIT = 8;
    localparam int unsigned DUR_MSB  = 7;
    localparam int unsigned DUR_LSB  = 0;

    // One-hot key drive; rests and out-of-range key indices stay silent.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] key,
                                                       input logic       rest);
        logic [NUM_KEYS-1:0] oh;
        oh = '0;
        if (!rest && (key < 4'(NUM_KEYS))) begin
            oh = NUM_KEYS'(1) << key;
        end
        return oh;
    endfunction

    // Octave shifted by a signed transpose and saturated to 0..7.
    // Sum is widened so the largest case (7+3) saturates instead of wrapping.
    function automatic logic [2:0] oct_transpose(input logic [2:0] oct,
                                                 input logic [2:0] tr);
        logic signed [4:0] sum;
        sum = $signed({2'b00, oct}) + $signed({{2{tr[2]}}, tr});
        if (sum < 5'sd0) begin
            return 3'd0;
        end
        if (sum > 5'sd7) begin
            return 3'd7;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/piano_melody_sequencer_vol_tracker.sv
// Steers the tone block's volume toward a target with spaced up/down pulses.
module piano_vol_tracker
    import piano_seq_pkg::*;
#(
    parameter int unsigned VOL_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] target_vol,
    input  logic [3:0] volume_monitor,
    output logic       vol_up,
    output logic       vol_down
);

    localparam int unsigned WW = $clog2(VOL_WAIT);

    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nx;
    logic          up_nx;
    logic          down_nx;

    // Compare only when the hold-off counter has drained; a pulse re-arms it.
    always_comb begin
        wait_nx = wait_cnt;
        up_nx   = 1'b0;
        down_nx = 1'b0;
        if (wait_cnt != '0) begin
            wait_nx = wait_cnt - WW'(1);
        end else if (target_vol > volume_monitor) begin
            up_nx   = 1'b1;
            wait_nx = WW'(VOL_WAIT - 1);
        end else if (target_vol < volume_monitor) begin
            down_nx = 1'b1;
            wait_nx = WW'(VOL_WAIT - 1);
        end
    end

    // Pulse and hold-off registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            vol_up   <= 1'b0;
            vol_down <= 1'b0;
        end else begin
            wait_cnt <= wait_nx;
            vol_up   <= up_nx;
            vol_down <= down_nx;
        end
    end

endmodule

// File: rtl/piano_melody_sequencer.sv
// Melody sequencer driving the 12-key piano tone block.
// Optional transpose input enabled by defining PIANO_SEQ_TRANSPOSE_EN.
module piano_melody_sequencer
    import piano_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1000000,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned GAP_TICKS = 1,
    parameter int unsigned VOL_WAIT  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [15:0]                wr_data,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic [3:0]                 target_vol,
    input  logic [3:0]                 volume_monitor,
`ifdef PIANO_SEQ_TRANSPOSE_EN
    input  logic [2:0]                 transpose,
`endif
    output logic [NUM_KEYS-1:0]        piano_keys,
    output logic [2:0]                 octave_num,
    output logic                       play_en,
    output logic                       vol_up,
    output logic                       vol_down,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   cur_step,
    output logic                       done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam int unsigned GW = $clog2(GAP_TICKS + 1);
    localparam int unsigned TW = (GW > 8) ? GW : 8;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rd_q;
    logic               rd_en;

    state_t              state, state_nx;
    logic                rd_phase, rd_phase_nx;
    logic [AW-1:0]       step, step_nx;
    logic [LW-1:0]       len, len_nx;
    logic [PW-1:0]       presc, presc_nx;
    logic [TW-1:0]       ticks, ticks_nx;
    logic [NUM_KEYS-1:0] keys_nx;
    logic [2:0]          oct_nx;
    logic                active, active_nx;
    logic                done_nx;
    logic                tick;
    logic                end_step;

    logic [3:0]          rd_key;
    logic [2:0]          rd_oct;
    logic                rd_rest;
    logic [7:0]          rd_dur;
    logic [2:0]          oct_sel;

    assign rd_key  = rd_q[KEY_MSB:KEY_LSB];
    assign rd_oct  = rd_q[OCT_MSB:OCT_LSB];
    assign rd_rest = rd_q[REST_BIT];
    assign rd_dur  = rd_q[DUR_MSB:DUR_LSB];

`ifdef PIANO_SEQ_TRANSPOSE_EN
    assign oct_sel = oct_transpose(rd_oct, transpose);
`else
    assign oct_sel = rd_oct;
`endif

    // Read is issued in the first LOAD cycle; data is used in the second.
    assign rd_en = (state == LOAD) && !rd_phase;

    // Melody store: one write port, registered read-first read port, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[step];
        end
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    // Next-state and registered-output logic for playback.
    always_comb begin
        state_nx    = state;
        rd_phase_nx = rd_phase;
        step_nx     = step;
        len_nx      = len;
        presc_nx    = presc;
        ticks_nx    = ticks;
        keys_nx     = piano_keys;
        oct_nx      = octave_num;
        active_nx   = active;
        done_nx     = 1'b0;
        end_step    = 1'b0;

        case (state)
            IDLE: begin
                if (start && (seq_len != '0)) begin
                    len_nx      = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
                    step_nx     = '0;
                    rd_phase_nx = 1'b0;
                    active_nx   = 1'b1;
                    state_nx    = LOAD;
                end
            end
            LOAD: begin
                if (!rd_phase) begin
                    rd_phase_nx = 1'b1;
                end else begin
                    rd_phase_nx = 1'b0;
                    presc_nx    = '0;
                    ticks_nx    = (rd_dur == 8'd0) ? TW'(1) : TW'(rd_dur);
                    keys_nx     = key_onehot(rd_key, rd_rest);
                    oct_nx      = oct_sel;
                    state_nx    = NOTE;
                end
            end
            NOTE: begin
                presc_nx = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (ticks == TW'(1)) begin
                        if (GAP_TICKS > 0) begin
                            keys_nx  = '0;
                            ticks_nx = TW'(GAP_TICKS);
                            state_nx = GAP;
                        end else begin
                            end_step = 1'b1;
                        end
                    end else begin
                        ticks_nx = ticks - TW'(1);
                    end
                end
            end
            GAP: begin
                presc_nx = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (ticks == TW'(1)) begin
                        end_step = 1'b1;
                    end else begin
                        ticks_nx = ticks - TW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (end_step) begin
            keys_nx = '0;
            if ((LW'(step) + LW'(1)) < len) begin
                step_nx  = step + AW'(1);
                state_nx = LOAD;
            end else if (loop_en) begin
                step_nx  = '0;
                state_nx = LOAD;
            end else begin
                active_nx = 1'b0;
                done_nx   = 1'b1;
                state_nx  = IDLE;
            end
        end

        if (stop) begin
            state_nx    = IDLE;
            rd_phase_nx = 1'b0;
            keys_nx     = '0;
            active_nx   = 1'b0;
            done_nx     = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_phase   <= 1'b0;
            step       <= '0;
            len        <= '0;
            presc      <= '0;
            ticks      <= '0;
            piano_keys <= '0;
            octave_num <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_phase   <= rd_phase_nx;
            step       <= step_nx;
            len        <= len_nx;
            presc      <= presc_nx;
            ticks      <= ticks_nx;
            piano_keys <= keys_nx;
            octave_num <= oct_nx;
            active     <= active_nx;
            done       <= done_nx;
        end
    end

    assign busy     = active;
    assign play_en  = active;
    assign cur_step = step;

    piano_vol_tracker #(
        .VOL_WAIT (VOL_WAIT)
    ) u_vol (
        .clk            (clk),
        .reset          (reset),
        .target_vol     (target_vol),
        .volume_monitor (volume_monitor),
        .vol_up         (vol_up),
        .vol_down       (vol_down)
    );

endmodule

// File: tb/tb_piano_melody_sequencer.sv
// Self-checking bench for piano_melody_sequencer (TICK_DIV=4, GAP_TICKS=1, DEPTH=32).
module tb_piano_melody_sequencer;

    localparam int unsigned TD    = 4;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned GAPT  = 1;
    localparam int unsigned VW    = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned LW    = 6;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [LW-1:0] seq_len;
    logic [3:0]    target_vol;
    logic [3:0]    mon;
    logic [11:0]   piano_keys;
    logic [2:0]    octave_num;
    logic          play_en;
    logic          vol_up;
    logic          vol_down;
    logic          busy;
    logic [AW-1:0] cur_step;
    logic          done;
`ifdef PIANO_SEQ_TRANSPOSE_EN
    logic [2:0]    transpose;
`endif

    piano_melody_sequencer #(
        .TICK_DIV  (TD),
        .DEPTH     (DEPTH),
        .GAP_TICKS (GAPT),
        .VOL_WAIT  (VW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start          (start),
        .stop           (stop),
        .loop_en        (loop_en),
        .seq_len        (seq_len),
        .target_vol     (target_vol),
        .volume_monitor (mon),
`ifdef PIANO_SEQ_TRANSPOSE_EN
        .transpose      (transpose),
`endif
        .piano_keys     (piano_keys),
        .octave_num     (octave_num),
        .play_en        (play_en),
        .vol_up         (vol_up),
        .vol_down       (vol_down),
        .busy           (busy),
        .cur_step       (cur_step),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tone-block stand-in: the reported volume follows each pulse.
    initial mon = 4'd0;
    always @(posedge clk) begin
        if (vol_up) mon <= mon + 4'd1;
        else if (vol_down) mon <= mon - 4'd1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle view of the player.
    typedef struct packed {
        logic [11:0] keys;
        logic [2:0]  oct;
        logic        chk_oct;
        logic        act;
        logic        done;
        logic [4:0]  step;
    } exp_t;

    exp_t        q[$];
    logic [15:0] bm [DEPTH];

    function automatic logic [31:0] dut_vec(input logic use_oct);
        return {9'b0, piano_keys, (use_oct ? octave_num : 3'b000), busy, play_en, done, cur_step};
    endfunction

    function automatic logic [31:0] exp_vec(input exp_t e);
        return {9'b0, e.keys, (e.chk_oct ? e.oct : 3'b000), e.act, e.act, e.done, e.step};
    endfunction

    // Reference rules for one melody entry.
    function automatic logic [11:0] model_keys(input logic [15:0] e);
        int k;
        k = int'(e[15:12]);
        if (e[8] || k >= 12) return 12'h000;
        return 12'(1 << k);
    endfunction

    function automatic int model_cycles(input logic [15:0] e);
        int d;
        d = int'(e[7:0]);
        if (d == 0) d = 1;
        return d * int'(TD);
    endfunction

    function automatic logic [2:0] model_oct(input logic [15:0] e);
`ifdef PIANO_SEQ_TRANSPOSE_EN
        int o;
        o = int'(e[11:9]) + int'($signed(transpose));
        if (o < 0) o = 0;
        if (o > 7) o = 7;
        return 3'(o);
`else
        return e[11:9];
`endif
    endfunction

    // One step: two silent load cycles, the note, then the articulation gap.
    function automatic void push_step(input int idx, input logic [11:0] keys,
                                      input logic [2:0] oct, input int ncyc);
        for (int i = 0; i < 2; i++) q.push_back('{12'h0, 3'd0, 1'b0, 1'b1, 1'b0, 5'(idx)});
        for (int i = 0; i < ncyc; i++) q.push_back('{keys, oct, 1'b1, 1'b1, 1'b0, 5'(idx)});
        for (int i = 0; i < int'(GAPT * TD); i++) q.push_back('{12'h0, oct, 1'b1, 1'b1, 1'b0, 5'(idx)});
    endfunction

    function automatic void push_end(input int last);
        q.push_back('{12'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'(last)});
        for (int i = 0; i < 2; i++) q.push_back('{12'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'(last)});
    endfunction

    task automatic write_entry(input int addr, input logic [15:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        bm[addr] = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Pulse start, then compare the DUT against the queued expectation every cycle.
    task automatic run_queue(input string name, input int seq, input int drop_idx);
        @(negedge clk);
        start   = 1'b1;
        seq_len = LW'(seq);
        loop_en = (drop_idx >= 0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) @(negedge clk);
            check(name, dut_vec(q[i].chk_oct), exp_vec(q[i]));
            start = (i == 3);
            if (i == drop_idx) loop_en = 1'b0;
        end
        start = 1'b0;
        q.delete();
    endtask

    task automatic vol_run(input string name, input logic [3:0] tgt, input int cycles,
                           input int exp_up, input int exp_down);
        int nup, ndown, last, minsp, both;
        nup = 0; ndown = 0; last = -1; minsp = 1000; both = 0;
        target_vol = tgt;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (vol_up && vol_down) both++;
            if (vol_up || vol_down) begin
                if (last >= 0 && (c - last) < minsp) minsp = c - last;
                last = c;
                if (vol_up) nup++;
                else ndown++;
            end
        end
        check({name, "_up"}, 32'(nup), 32'(exp_up));
        check({name, "_down"}, 32'(ndown), 32'(exp_down));
        check({name, "_spacing_ok"}, 32'(minsp >= int'(VW)), 32'd1);
        check({name, "_both"}, 32'(both), 32'd0);
        check({name, "_mon"}, 32'(mon), 32'(tgt));
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [2:0]  oct;
        logic        rest;
        logic [7:0]  dur;
        logic [11:0] exp_keys;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{4'd9,  3'd4, 1'b0, 8'd2, 12'h200, 8};
        tbl[1] = '{4'd0,  3'd5, 1'b0, 8'd1, 12'h001, 4};
        tbl[2] = '{4'd11, 3'd7, 1'b0, 8'd1, 12'h800, 4};
        tbl[3] = '{4'd3,  3'd2, 1'b1, 8'd2, 12'h000, 8};
        tbl[4] = '{4'd13, 3'd1, 1'b0, 8'd1, 12'h000, 4};
        tbl[5] = '{4'd12, 3'd0, 1'b0, 8'd1, 12'h000, 4};
        tbl[6] = '{4'd5,  3'd3, 1'b0, 8'd0, 12'h020, 4};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; seq_len = '0; target_vol = 4'd0;
`ifdef PIANO_SEQ_TRANSPOSE_EN
        transpose = 3'd0;
`endif
        repeat (2) @(negedge clk);
        check("reset_state", {dut_vec(1'b1)[29:0], vol_up, vol_down}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("after_reset", {dut_vec(1'b1)[29:0], vol_up, vol_down}, 32'h0);

        // Two-step melody with literal expectations.
        write_entry(0, {4'd9, 3'd4, 1'b0, 8'd2});
        write_entry(1, {4'd0, 3'd5, 1'b0, 8'd1});
        push_step(0, 12'h200, 3'd4, 8);
        push_step(1, 12'h001, 3'd5, 4);
        push_end(1);
        run_queue("two_step", 2, -1);

        // Single-entry decode table.
        foreach (tbl[i]) begin
            write_entry(0, {tbl[i].key, tbl[i].oct, tbl[i].rest, tbl[i].dur});
            push_step(0, tbl[i].exp_keys, tbl[i].oct, tbl[i].exp_cyc);
            push_end(0);
            run_queue($sformatf("vec%0d", i), 1, -1);
        end

        // Looping a one-step melody, loop_en dropped during the third pass.
        write_entry(0, {4'd4, 3'd3, 1'b0, 8'd1});
        for (int r = 0; r < 3; r++) push_step(0, 12'h010, 3'd3, 4);
        push_end(0);
        run_queue("loop", 1, 25);

        // stop mid-note: silent and idle next cycle, no done.
        write_entry(0, {4'd7, 3'd2, 1'b0, 8'd3});
        @(negedge clk); start = 1'b1; seq_len = LW'(1);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_pre", {20'b0, piano_keys}, 32'h080);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        check("stop_now", dut_vec(1'b0), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stop_after", dut_vec(1'b0), 32'h0);
        end

        // start and stop together: stop wins.
        start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("start_stop", {30'b0, busy, play_en}, 32'h0);
            @(negedge clk);
        end

        // seq_len=0 is ignored.
        start = 1'b1; seq_len = '0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len_zero", {30'b0, busy, play_en}, 32'h0);
            @(negedge clk);
        end

        // Asynchronous reset mid-note.
        start = 1'b1; seq_len = LW'(1);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", {dut_vec(1'b1)[29:0], vol_up, vol_down}, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Randomized melodies against the reference rules.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(1, 5));
            for (int a = 0; a < len; a++) begin
                logic [15:0] e;
                e = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 5) == 0), 8'($urandom_range(0, 2))};
                write_entry(a, e);
            end
            for (int a = 0; a < len; a++) push_step(a, model_keys(bm[a]), model_oct(bm[a]), model_cycles(bm[a]));
            push_end(len - 1);
            run_queue($sformatf("rand%0d", r), len, -1);
        end

        // seq_len above DEPTH plays every entry once.
        for (int a = 0; a < int'(DEPTH); a++) begin
            write_entry(a, {4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0,
                            8'($urandom_range(0, 1))});
        end
        for (int a = 0; a < int'(DEPTH); a++) push_step(a, model_keys(bm[a]), model_oct(bm[a]), model_cycles(bm[a]));
        push_end(int'(DEPTH) - 1);
        run_queue("len40", 40, -1);

`ifdef PIANO_SEQ_TRANSPOSE_EN
        write_entry(0, {4'd0, 3'd6, 1'b0, 8'd1});
        transpose = 3'd3;
        push_step(0, 12'h001, 3'd7, 4);
        push_end(0);
        run_queue("transpose_up", 1, -1);
        write_entry(0, {4'd2, 3'd2, 1'b0, 8'd1});
        transpose = 3'b100;
        push_step(0, 12'h004, 3'd0, 4);
        push_end(0);
        run_queue("transpose_dn", 1, -1);
        transpose = 3'd0;
`endif

        // Volume tracking with the monitor following each pulse.
        vol_run("vol_to3", 4'd3, 30, 3, 0);
        vol_run("vol_to1", 4'd1, 30, 0, 2);
        vol_run("vol_hold", 4'd1, 10, 0, 0);
        for (int r = 0; r < 4; r++) begin
            logic [3:0] t;
            int diff;
            t = 4'($urandom_range(0, 15));
            diff = int'(t) - int'(mon);
            vol_run($sformatf("vol_rand%0d", r), t, 16 * int'(VW) + 8,
                    (diff > 0) ? diff : 0, (diff < 0) ? -diff : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
